fifo_param: RTL and testbench
=============================

// Module: fifo_param
// PURPOSE
//  Parametrised synchronous FIFO, next generation of the team's 8x10 FIFO.
//  Depth, width and almost-thresholds are configurable. Write-when-full and read-when-empty are blocked, not corrupting.
//  Reports occupancy plus overflow/underflow. Sits between producer/consumer blocks on one clock domain.
// PARAMETERS
//  DATA_WIDTH  10  width of data_in/data_out
//  DEPTH       8   number of entries; power of two, >=4
//  AF_THRESH   6   almost_full asserted when count >= AF_THRESH (1..DEPTH-1)
//  AE_THRESH   1   almost_empty asserted when count <= AE_THRESH (0..DEPTH-2)
//  localparam ADDR_WIDTH = $clog2(DEPTH)
// PORTS
//  clk           in   1             single clock, rising edge
//  reset         in   1             asynchronous, active-high
//  wr_en         in   1             write request
//  data_in       in   DATA_WIDTH    write data
//  rd_en         in   1             read request
//  data_out      out  DATA_WIDTH    read data, registered
//  valid         out  1             data_out holds a newly read word this cycle
//  full/empty    out  1             count==DEPTH / count==0
//  almost_full   out  1             count >= AF_THRESH
//  almost_empty  out  1             count <= AE_THRESH
//  count         out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//  overflow      out  1             write rejected (see CONFIGURATION)
//  underflow     out  1             read rejected (see CONFIGURATION)
//  err_clr       in   1             clears sticky error flags
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk release): wr_ptr=rd_ptr=0, count=0, data_out=0, valid=0.
//    Also overflow=underflow=0. Outputs settle to empty=1, full=0, almost_full=0, almost_empty=1.
//    Reset mid-operation discards all contents immediately.
//  - rd_acc = rd_en & ~empty.
//  - wr_acc = wr_en & (~full | rd_acc). Full + simultaneous read+write is allowed; count stays DEPTH.
//  - Empty + simultaneous read+write: read rejected (underflow), write accepted, count->1.
//    No bypass path exists.
//  - Read latency 1: on rd_acc, data_out <= mem[rd_ptr] at the next edge and valid=1 for that cycle.
//    data_out holds its last value when valid=0.
//  - Pointers are ADDR_WIDTH bits and wrap naturally DEPTH-1 -> 0. They advance only on wr_acc/rd_acc.
//  - count update: +1 on wr_acc&~rd_acc, -1 on rd_acc&~wr_acc, else hold. count never exceeds DEPTH or goes below 0.
//  - Flags are combinational from the count register, so they change the cycle after the accepting edge.
//  - Write data is visible to a read issued the cycle after it is written.
// CONFIGURATION
//  Macro FIFO_STICKY_ERR_EN:
//   defined:   overflow sets on (wr_en & ~wr_acc); underflow sets on (rd_en & ~rd_acc).
//              Both hold until err_clr=1 at a clock edge. A set and err_clr in the same cycle results in set.
//   undefined: overflow/underflow are 1-cycle registered pulses, asserted the cycle after the rejected request.
//              err_clr is ignored.
// STRUCTURE
//  - Package fifo_pkg: default DATA_WIDTH/DEPTH/threshold constants, plus a clog2 helper for ADDR_WIDTH.
//  - Sub-module fifo_mem_2p: simple dual-port RAM, DEPTH x DATA_WIDTH.
//    Write port: synchronous, gated by wr_acc. Read port: registered, gated by rd_acc.
//  - fifo_param owns pointers, count, flags, error logic and the valid register.
// TESTING
//  1. Reset: assert reset mid-stream with count=5 -> count=0, empty=1, valid=0 immediately, without a clock edge.
//  2. Fill: DEPTH=8, write 0x001..0x008 -> count=8, full=1, almost_full from count=6.
//     A 9th write -> overflow, count stays 8.
//  3. Drain: read 8 times -> data_out 0x001..0x008 in order, each with valid=1 one cycle after rd_en.
//     A 9th read -> underflow, valid=0.
//  4. Wrap: 20 cycles of write+read at count=3 -> count stays 3, order preserved across the pointer wrap.
//  5. Boundary simultaneity: full+wr+rd -> both accepted, count=8; empty+wr+rd -> write only, count=1, underflow.
//  6. Errors: with FIFO_STICKY_ERR_EN, overflow holds until err_clr. Without it, overflow is a 1-cycle pulse.
//     Run under DEPTH=16, DATA_WIDTH=32, AF_THRESH=12, AE_THRESH=3.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the parametrised FIFO.
package fifo_pkg;

   localparam int DEF_DATA_WIDTH = 10;
   localparam int DEF_DEPTH      = 8;
   localparam int DEF_AF_THRESH  = 6;
   localparam int DEF_AE_THRESH  = 1;

   // Constant-evaluable ceil(log2(v)); returns 0 for v <= 1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_if.sv
// Producer/consumer handshake bundle for fifo_param; master = client side, slave = FIFO side.
interface fifo_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
);
   localparam int ADDR_WIDTH = clog2(DEPTH);

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  rd_en;
   logic                  err_clr;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, data_in, rd_en, err_clr,
      input  data_out, valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  wr_en, data_in, rd_en, err_clr,
      output data_out, valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

endinterface

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage: synchronous write, registered read with resettable output.
module fifo_mem_2p
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_WIDTH = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Array itself is not reset so it can map onto RAM macros.
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;

   // Same-address write+read (full FIFO, simultaneous access) returns the old word.
   always_ff @(posedge clk or posedge reset)
      if (reset)   rdata <= '0;
      else if (re) rdata <= mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: pointers, occupancy, flags and error reporting.
// Define FIFO_STICKY_ERR_EN for sticky overflow/underflow cleared by err_clr; otherwise 1-cycle pulses.
module fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int AF_THRESH  = DEF_AF_THRESH,
   parameter int AE_THRESH  = DEF_AE_THRESH
) (
   input  logic  clk,
   input  logic  reset,
   fifo_if.slave bus
);

   localparam int ADDR_WIDTH = clog2(DEPTH);
   localparam int CW         = ADDR_WIDTH + 1;

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic                  valid_q;
   logic                  overflow_q, underflow_q;
   logic [DATA_WIDTH-1:0] rdata;

   logic full, empty;
   logic rd_acc, wr_acc;
   logic ovf_evt, unf_evt;

   assign full   = (count == FULL_CNT);
   assign empty  = (count == '0);

   // A full FIFO still takes a write when a read frees a slot in the same cycle;
   // an empty FIFO never forwards the incoming word.
   assign rd_acc = bus.rd_en & ~empty;
   assign wr_acc = bus.wr_en & (~full | rd_acc);

   assign ovf_evt = bus.wr_en & ~wr_acc;
   assign unf_evt = bus.rd_en & ~rd_acc;

   fifo_mem_2p #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (bus.data_in),
      .re    (rd_acc),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         valid_q <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         valid_q <= rd_acc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
`ifdef FIFO_STICKY_ERR_EN
         // A new event wins over a simultaneous clear.
         overflow_q  <= ovf_evt | (overflow_q  & ~bus.err_clr);
         underflow_q <= unf_evt | (underflow_q & ~bus.err_clr);
`else
         overflow_q  <= ovf_evt;
         underflow_q <= unf_evt;
`endif
      end
   end

`ifndef FIFO_STICKY_ERR_EN
   logic unused_err_clr;
   assign unused_err_clr = bus.err_clr;
`endif

   assign bus.data_out     = rdata;
   assign bus.valid        = valid_q;
   assign bus.count        = count;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count >= AF_CNT);
   assign bus.almost_empty = (count <= AE_CNT);
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param against a queue-based reference model.
module tb_fifo_param;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int AF    = 12;
   localparam int AE    = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] exp_data = '0;
   logic          exp_valid = 1'b0;
   logic          exp_ovf = 1'b0;
   logic          exp_unf = 1'b0;

   always #5 clk = ~clk;

   fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

   fifo_param #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .AF_THRESH  (AF),
      .AE_THRESH  (AE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      chk({tag, ".count"},    DW'(bus.count),       DW'(n));
      chk({tag, ".full"},     DW'(bus.full),        DW'(n == DEPTH));
      chk({tag, ".empty"},    DW'(bus.empty),       DW'(n == 0));
      chk({tag, ".afull"},    DW'(bus.almost_full), DW'(n >= AF));
      chk({tag, ".aempty"},   DW'(bus.almost_empty),DW'(n <= AE));
      chk({tag, ".valid"},    DW'(bus.valid),       DW'(exp_valid));
      chk({tag, ".data_out"}, bus.data_out,         exp_data);
      chk({tag, ".overflow"}, DW'(bus.overflow),    DW'(exp_ovf));
      chk({tag, ".underflow"},DW'(bus.underflow),   DW'(exp_unf));
   endtask

   task automatic model_reset();
      q.delete();
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
   endtask

   // One clock: drive, let the edge happen, advance the model, check 1 time unit later.
   task automatic cycle(input string tag, input logic w, input logic [DW-1:0] d,
                        input logic r, input logic c);
      bit ra, wa, ov, un;
      bus.wr_en   = w;
      bus.data_in = d;
      bus.rd_en   = r;
      bus.err_clr = c;
      @(posedge clk);
      ra = r && (q.size() > 0);
      wa = w && ((q.size() < DEPTH) || ra);
      ov = w && !wa;
      un = r && !ra;
      exp_valid = ra;
      if (ra) exp_data = q.pop_front();
      if (wa) q.push_back(d);
`ifdef FIFO_STICKY_ERR_EN
      exp_ovf = ov || (exp_ovf && !c);
      exp_unf = un || (exp_unf && !c);
`else
      exp_ovf = ov;
      exp_unf = un;
`endif
      #1;
      check_all(tag);
   endtask

   initial begin
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.err_clr = 1'b0;
      bus.data_in = '0;
      model_reset();
      #12;
      check_all("reset");
      reset = 1'b0;
      cycle("idle", 1'b0, '0, 1'b0, 1'b0);

      // Fill to full, then one rejected write, then idle and clear.
      for (int i = 1; i <= DEPTH; i++) cycle("fill", 1'b1, DW'(i), 1'b0, 1'b0);
      cycle("overfill", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      cycle("ovf_hold", 1'b0, '0, 1'b0, 1'b0);
      cycle("ovf_clr", 1'b0, '0, 1'b0, 1'b1);
      cycle("ovf_after", 1'b0, '0, 1'b0, 1'b0);

      // Drain in order, then one rejected read.
      for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);
      cycle("underread", 1'b0, '0, 1'b1, 1'b0);
      cycle("unf_clr", 1'b0, '0, 1'b0, 1'b1);

      // Async reset mid-stream with count=5 and valid high.
      for (int i = 0; i < 6; i++) cycle("pre_rst", 1'b1, 32'h100 + DW'(i), 1'b0, 1'b0);
      cycle("pre_rst_rd", 1'b0, '0, 1'b1, 1'b0);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      #3 reset = 1'b0;

      // Steady write+read at count=3 across pointer wrap.
      for (int i = 0; i < 3; i++) cycle("wrap_fill", 1'b1, $urandom, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle("wrap", 1'b1, $urandom, 1'b1, 1'b0);

      // Full + write + read, then empty + write + read.
      while (q.size() < DEPTH) cycle("to_full", 1'b1, $urandom, 1'b0, 1'b0);
      cycle("full_wr_rd", 1'b1, 32'hF00D_0001, 1'b1, 1'b0);
      while (q.size() > 0) cycle("to_empty", 1'b0, '0, 1'b1, 1'b0);
      cycle("empty_wr_rd", 1'b1, 32'hF00D_0002, 1'b1, 1'b0);
      cycle("empty_wr_rd_nxt", 1'b0, '0, 1'b1, 1'b0);

      // Random traffic.
      for (int i = 0; i < 400; i++)
         cycle("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 7) == 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
